// File: rtl/traffic_light_sequencer.sv
// Six-phase intersection controller: NS/EW light heads, phase countdown,
// latched pedestrian green truncation and an all-red flash mode on fault.
module traffic_light_sequencer #(
  parameter int unsigned SCALER      = 50000000,
  parameter int unsigned GREEN_S     = 20,
  parameter int unsigned YELLOW_S    = 4,
  parameter int unsigned ALLRED_S    = 2,
  parameter int unsigned MIN_GREEN_S = 5
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ped_req,
  input  logic        fault,
  output logic [2:0]  ns_lights,
  output logic [2:0]  ew_lights,
  output logic [31:0] clock_ticks,
  output logic        ped_walk,
  output logic [2:0]  phase
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5,
    FLASH     = 3'd6
  } phase_e;

  // Phase reload values: a phase of D seconds counts D*SCALER-1 down to 0.
  localparam logic [31:0] GREEN_T  = GREEN_S * SCALER - 32'd1;
  localparam logic [31:0] YELLOW_T = YELLOW_S * SCALER - 32'd1;
  localparam logic [31:0] ALLRED_T = ALLRED_S * SCALER - 32'd1;
  localparam logic [31:0] MIN_T    = MIN_GREEN_S * SCALER - 32'd1;
  localparam logic [31:0] FLASH_T  = SCALER - 32'd1;
  localparam logic [31:0] HALF_T   = SCALER / 32'd2;
  localparam logic [31:0] WALK_T   = YELLOW_S * SCALER;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  phase_e      phase_q, phase_d;
  logic [31:0] ticks_q, ticks_d;
  logic        ped_pending_q, ped_pending_d;
  logic [2:0]  ns_q, ns_d;
  logic [2:0]  ew_q, ew_d;
  logic        walk_q, walk_d;
  logic        ped_any;
  logic        is_green;

  function automatic phase_e next_phase(input phase_e p);
    case (p)
      NS_GREEN:  return NS_YELLOW;
      NS_YELLOW: return ALLRED_A;
      ALLRED_A:  return EW_GREEN;
      EW_GREEN:  return EW_YELLOW;
      EW_YELLOW: return ALLRED_B;
      ALLRED_B:  return NS_GREEN;
      default:   return ALLRED_B;
    endcase
  endfunction

  function automatic logic [31:0] phase_load(input phase_e p);
    case (p)
      NS_GREEN, EW_GREEN:   return GREEN_T;
      NS_YELLOW, EW_YELLOW: return YELLOW_T;
      FLASH:                return FLASH_T;
      default:              return ALLRED_T;
    endcase
  endfunction

  assign ped_any  = ped_pending_q | ped_req;
  assign is_green = (phase_q == NS_GREEN) || (phase_q == EW_GREEN);

  always_comb begin
    phase_d       = phase_q;
    ticks_d       = ticks_q;
    ped_pending_d = ped_any;

    if (fault) begin
      phase_d = FLASH;
      if (phase_q != FLASH || ticks_q == 32'd0) begin
        ticks_d = FLASH_T;
      end else begin
        ticks_d = ticks_q - 32'd1;
      end
    end else if (phase_q == FLASH || phase_q == 3'd7) begin
      // Leaving flash (or an illegal encoding) always resumes via clearance.
      phase_d = ALLRED_B;
      ticks_d = ALLRED_T;
    end else if (ticks_q == 32'd0) begin
      phase_d = next_phase(phase_q);
      ticks_d = phase_load(next_phase(phase_q));
    end else if (is_green && ped_any) begin
      ped_pending_d = 1'b0;
      if (ticks_q > MIN_T) begin
        ticks_d = MIN_T;
      end else begin
        ticks_d = ticks_q - 32'd1;
      end
    end else begin
      ticks_d = ticks_q - 32'd1;
    end

    ns_d   = RED;
    ew_d   = RED;
    walk_d = 1'b0;
    case (phase_d)
      NS_GREEN: begin
        ns_d   = GRN;
        walk_d = (ticks_d >= WALK_T);
      end
      NS_YELLOW: ns_d = YEL;
      EW_GREEN: begin
        ew_d   = GRN;
        walk_d = (ticks_d >= WALK_T);
      end
      EW_YELLOW: ew_d = YEL;
      FLASH: begin
        ns_d = (ticks_d >= HALF_T) ? RED : OFF;
        ew_d = (ticks_d >= HALF_T) ? RED : OFF;
      end
      default: begin
        ns_d = RED;
        ew_d = RED;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      phase_q       <= ALLRED_B;
      ticks_q       <= ALLRED_T;
      ped_pending_q <= 1'b0;
      ns_q          <= RED;
      ew_q          <= RED;
      walk_q        <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      ticks_q       <= ticks_d;
      ped_pending_q <= ped_pending_d;
      ns_q          <= ns_d;
      ew_q          <= ew_d;
      walk_q        <= walk_d;
    end
  end

  assign phase       = phase_q;
  assign clock_ticks = ticks_q;
  assign ns_lights   = ns_q;
  assign ew_lights   = ew_q;
  assign ped_walk    = walk_q;

endmodule
